mem_access_unit: RTL and testbench

- Initiator-side controller for the word-addressable byte-lane data memory.
- Accepts byte, halfword and word load/store requests from the CPU datapath.
- Drives the memory's word address, 4-lane write data and write enable, and implements sub-word stores as read-modify-write.
- Returns aligned, optionally sign-extended load data to the CPU over a req/ready/done handshake.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store controller for a byte-lane, word-addressed data memory; sub-word stores are read-modify-write.
// Optional macro MAU_MISALIGN_CHECK_EN: reject half/word accesses whose low address bits are not aligned.
module mem_access_unit #(
    parameter logic [31:0] START       = 32'd0,
    parameter logic [31:0] TOP         = 32'd65535,
    parameter int          MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req,
    output logic        ready,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata [0:3],
    output logic        mem_we,
    input  logic [7:0]  mem_rdata [0:3]
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;
    localparam logic [1:0]  SZ_RSVD   = 2'd3;
    localparam logic [32:0] START_W   = {1'b0, START};
    localparam logic [32:0] TOP_W     = {1'b0, TOP};
    localparam logic [15:0] WAIT_LAST = 16'(MEM_LATENCY - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        err_q;
    logic        accept;
    logic        acc_err;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic [31:0] loaded;

    // Transaction fields captured at acceptance; only meaningful while busy.
    logic        st_store;
    logic [1:0]  st_size;
    logic        st_signed;
    logic [1:0]  st_off;
    logic [15:0] st_wdata;

    // Sub-word load: pick the addressed lane(s) and zero- or sign-extend.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Sub-word store: overlay the new byte/half onto the word just read.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE) begin
            case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (sz == SZ_HALF) begin
            if (off[1]) r[31:16] = d;
            else        r[15:0]  = d;
        end
        return r;
    endfunction

    assign ready   = (state == S_IDLE);
    assign accept  = ready && req;
    assign done    = (state == S_DONE);
    assign err     = done && err_q;
    // Decoded from state so an asynchronous reset removes the write strobe at once.
    assign mem_we  = (state == S_WRITE);
    assign rd_word = {mem_rdata[3], mem_rdata[2], mem_rdata[1], mem_rdata[0]};
    assign merged  = store_merge(rd_word, st_size, st_off, st_wdata);
    assign loaded  = load_extract(rd_word, st_size, st_off, st_signed);

    always_comb begin
        acc_err = (size == SZ_RSVD)
               || (({1'b0, addr} + 33'd1) <= START_W)
               || (({1'b0, addr} + 33'd3) > TOP_W);
`ifdef MAU_MISALIGN_CHECK_EN
        if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
            acc_err = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            st_store  <= is_store;
            st_size   <= size;
            st_signed <= is_signed;
            st_off    <= addr[1:0];
            st_wdata  <= wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            for (int i = 0; i < 4; i++) mem_wdata[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        mem_addr <= {addr[31:2], 2'b00};
                        wait_cnt <= '0;
                        err_q    <= acc_err;
                        if (acc_err) begin
                            state <= S_DONE;
                        end else if (is_store && size == SZ_WORD) begin
                            for (int i = 0; i < 4; i++) mem_wdata[i] <= wdata[8*i +: 8];
                            state <= S_WRITE;
                        end else begin
                            state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (st_store) begin
                            for (int i = 0; i < 4; i++) mem_wdata[i] <= merged[8*i +: 8];
                            state <= S_WRITE;
                        end else begin
                            rdata <= loaded;
                            state <= S_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WRITE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit against a 64 KiB byte-lane memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_b;
    logic        req;
    logic        ready;
    logic        is_store;
    logic [1:0]  size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata [0:3];
    logic        mem_we;
    logic [7:0]  mem_rdata [0:3];

    logic [7:0]  mem [0:65535];
    int          we_cnt;
    int          vectors;
    int          miscompares;
    logic [31:0] last_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.START(32'd0), .TOP(32'd65535), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .ready(ready), .is_store(is_store),
        .size(size), .is_signed(is_signed), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) mem_rdata[i] = mem[mem_addr[15:0] + 16'(i)];
    end

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) mem[mem_addr[15:0] + 16'(i)] <= mem_wdata[i];
            we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes_word();
        return {mem_wdata[3], mem_wdata[2], mem_wdata[1], mem_wdata[0]};
    endfunction

    task automatic run_op(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er,
                          input int exp_lat, input int exp_we);
        exp_t e;
        int   lat;
        int   we0;
        e.rdata = exp_rd;
        e.err   = exp_er;
        e.lat   = exp_lat;
        e.we    = exp_we;
        sb.push_back(e);
        @(negedge clk);
        check({tag, " ready"}, 32'(ready), 32'd1);
        is_store  = st;
        size      = sz;
        is_signed = sg;
        addr      = a;
        wdata     = wd;
        req       = 1'b1;
        we0       = we_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " err"}, 32'(err), 32'(e.err));
        check({tag, " rdata"}, rdata, e.rdata);
        check({tag, " we_cycles"}, 32'(we_cnt - we0), 32'(e.we));
        check({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        if (!e.err && !st) last_rdata = e.rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] done_seq;
        logic [4:0] ready_seq;
        vectors     = 0;
        miscompares = 0;
        we_cnt      = 0;
        last_rdata  = 32'h0;
        rst_b       = 1'b0;
        req         = 1'b0;
        is_store    = 1'b0;
        size        = 2'd0;
        is_signed   = 1'b0;
        addr        = 32'h0;
        wdata       = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst rdata", rdata, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst lanes", lanes_word(), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;

        run_op("st_w 100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h8899AABB, last_rdata, 1'b0, 2, 1);
        run_op("ld_bs 101", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        run_op("ld_bu 103", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h00000088, 1'b0, 2, 0);
        run_op("ld_hs 100", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);

        run_op("st_w 200", 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, last_rdata, 1'b0, 2, 1);
        check("st_w 200 lanes", lanes_word(), 32'hDEADBEEF);
        run_op("ld_w 200", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        run_op("st_w 300", 1'b1, 2'd2, 1'b0, 32'h300, 32'h11223344, last_rdata, 1'b0, 2, 1);
        run_op("st_h 302", 1'b1, 2'd1, 1'b0, 32'h302, 32'h1234CAFE, last_rdata, 1'b0, 3, 1);
        check("st_h 302 lanes", lanes_word(), 32'hCAFE3344);
        run_op("ld_w 300", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE3344, 1'b0, 2, 0);
        run_op("ld_hu 302", 1'b0, 2'd1, 1'b0, 32'h302, 32'h0, 32'h0000CAFE, 1'b0, 2, 0);
        run_op("ld_hs 302", 1'b0, 2'd1, 1'b1, 32'h302, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 0);

        run_op("st_b 200", 1'b1, 2'd0, 1'b0, 32'h200, 32'hAAAAAA55, last_rdata, 1'b0, 3, 1);
        run_op("ld_w 200b", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEADBE55, 1'b0, 2, 0);

        run_op("err top", 1'b0, 2'd2, 1'b0, 32'hFFFE, 32'h0, last_rdata, 1'b1, 1, 0);
        run_op("err size3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, last_rdata, 1'b1, 1, 0);
        run_op("err st top", 1'b1, 2'd2, 1'b0, 32'hFFFD, 32'h12345678, last_rdata, 1'b1, 1, 0);

`ifdef MAU_MISALIGN_CHECK_EN
        run_op("ld_h 301", 1'b0, 2'd1, 1'b0, 32'h301, 32'h0, last_rdata, 1'b1, 1, 0);
`else
        run_op("ld_h 301", 1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 32'h00003344, 1'b0, 2, 0);
`endif

        // Request held high across a busy period: second acceptance only after DONE.
        @(negedge clk);
        is_store  = 1'b0;
        size      = 2'd2;
        is_signed = 1'b0;
        addr      = 32'h200;
        req       = 1'b1;
        done_seq  = '0;
        ready_seq = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            done_seq[k]  = done;
            ready_seq[k] = ready;
        end
        req = 1'b0;
        check("held done pattern", 32'(done_seq), 32'(5'b10010));
        check("held ready pattern", 32'(ready_seq), 32'(5'b00100));
        check("held rdata", rdata, 32'hDEADBE55);
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted while a byte store is in its write cycle.
        @(negedge clk);
        is_store  = 1'b1;
        size      = 2'd0;
        addr      = 32'h300;
        wdata     = 32'h00000077;
        req       = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid we before", 32'(mem_we), 32'd1);
        #1 rst_b = 1'b0;
        #1;
        check("rst_mid we dropped", 32'(mem_we), 32'd0);
        check("rst_mid ready", 32'(ready), 32'd1);
        check("rst_mid done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid byte kept", 32'(mem[16'h300]), 32'h44);
        check("rst_mid rdata", rdata, 32'h0);
        @(negedge clk);
        rst_b      = 1'b1;
        last_rdata = 32'h0;
        run_op("ld_w 300 post", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE3344, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
